// File: rtl/hs_responder.sv
// hs_responder: responder side of the req/ack handshake.
// Waits ACK_DELAY cycles, pulses Ack once, then waits for Req to drop.
module hs_responder #(
    parameter int ACK_DELAY = 2,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             Req,
    input  logic             En,
    input  logic             ClrErr,
    output logic             Ack,
    output logic             Busy,
    output logic             Err,
    output logic [CNT_W-1:0] TxnCount
);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        WAIT    = 2'b01,
        ACK     = 2'b10,
        RELEASE = 2'b11
    } state_t;

    localparam bit              NO_DLY = (ACK_DELAY == 0);
    localparam int              LAST_I = NO_DLY ? 0 : ACK_DELAY - 1;
    localparam logic [3:0]      LAST   = LAST_I[3:0];
    localparam logic [CNT_W-1:0] ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t     state;
    logic [3:0] cnt;

    // Ack and Busy are registered alongside the state they mirror.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            Ack      <= 1'b0;
            Busy     <= 1'b0;
            Err      <= 1'b0;
            TxnCount <= '0;
        end else begin
            if (ClrErr)
                Err <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (Req && En) begin
                        Busy <= 1'b1;
                        if (NO_DLY) begin
                            state <= ACK;
                            Ack   <= 1'b1;
                        end else begin
                            state <= WAIT;
                            cnt   <= 4'd0;
                        end
                    end
                end
                WAIT: begin
                    if (!Req) begin
                        // set wins over a same-cycle ClrErr
                        Err   <= 1'b1;
                        state <= IDLE;
                        Busy  <= 1'b0;
                    end else if (cnt == LAST) begin
                        state <= ACK;
                        Ack   <= 1'b1;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                ACK: begin
                    state    <= RELEASE;
                    Ack      <= 1'b0;
                    TxnCount <= TxnCount + ONE;
                end
                RELEASE: begin
                    if (!Req) begin
                        state <= IDLE;
                        Busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    Ack   <= 1'b0;
                    Busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hs_responder.sv
// Directed bench for hs_responder: three instances cover
// delay 2 / delay 0 / 2-bit counter wrap.
module tb_hs_responder;

    logic clk = 1'b0;
    logic rst;

    logic req_m, use_init, en_a, clr_a;
    logic req_a;
    logic ack_a, busy_a, err_a;
    logic [7:0] txn_a;

    logic req_z, en_z;
    logic ack_z, busy_z, err_z;
    logic [7:0] txn_z;

    logic req_w, en_w;
    logic ack_w, busy_w, err_w;
    logic [1:0] txn_w;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    // initiator model: 2-bit sequencer raising Out after a post-reset delay
    logic [1:0] ist;
    logic [1:0] dcnt;
    logic       init_out;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            ist  <= 2'd0;
            dcnt <= 2'd0;
        end else begin
            case (ist)
                2'd0: if (dcnt == 2'd2) ist <= 2'd1;
                      else dcnt <= dcnt + 2'd1;
                2'd1: if (ack_a) ist <= 2'd2;
                2'd2: ist <= 2'd3;
                default: ist <= 2'd1;
            endcase
        end
    end

    assign init_out = (ist == 2'd1) || (ist == 2'd2);
    assign req_a    = use_init ? init_out : req_m;

    hs_responder #(.ACK_DELAY(2), .CNT_W(8)) u_a (
        .clk(clk), .rst(rst), .Req(req_a), .En(en_a),
        .ClrErr(clr_a), .Ack(ack_a), .Busy(busy_a),
        .Err(err_a), .TxnCount(txn_a)
    );

    hs_responder #(.ACK_DELAY(0), .CNT_W(8)) u_z (
        .clk(clk), .rst(rst), .Req(req_z), .En(en_z),
        .ClrErr(1'b0), .Ack(ack_z), .Busy(busy_z),
        .Err(err_z), .TxnCount(txn_z)
    );

    hs_responder #(.ACK_DELAY(1), .CNT_W(2)) u_w (
        .clk(clk), .rst(rst), .Req(req_w), .En(en_w),
        .ClrErr(1'b0), .Ack(ack_w), .Busy(busy_w),
        .Err(err_w), .TxnCount(txn_w)
    );

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "timeout");
    end

    logic       a_hist [0:19];
    logic       o_hist [0:19];
    logic [1:0] wrap_exp [0:4];
    int         bad;
    int         pulses;

    initial begin
        wrap_exp[0] = 2'd1; wrap_exp[1] = 2'd2; wrap_exp[2] = 2'd3;
        wrap_exp[3] = 2'd0; wrap_exp[4] = 2'd1;

        rst = 1'b0; use_init = 1'b0; req_m = 1'b0; en_a = 1'b0;
        clr_a = 1'b0; req_z = 1'b0; en_z = 1'b0;
        req_w = 1'b0; en_w = 1'b0;
        repeat (3) step();
        chk("rst_ack",  ack_a,  0);
        chk("rst_busy", busy_a, 0);
        chk("rst_err",  err_a,  0);
        chk("rst_txn",  txn_a,  0);

        rst = 1'b1;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (ack_a || busy_a || err_a || txn_a != 0) bad++;
        end
        chk("idle_quiet", bad, 0);

        // basic handshake, delay 2
        en_a = 1'b1; req_m = 1'b1;
        step();
        chk("b_e0_busy", busy_a, 1);
        chk("b_e0_ack",  ack_a,  0);
        step();
        chk("b_e1_ack",  ack_a,  0);
        step();
        chk("b_e2_ack",  ack_a,  1);
        step();
        chk("b_e3_ack",  ack_a,  0);
        chk("b_e3_txn",  txn_a,  1);
        chk("b_e3_busy", busy_a, 1);
        step();
        chk("b_e4_busy", busy_a, 1);
        req_m = 1'b0;
        step();
        chk("b_e5_busy", busy_a, 0);
        chk("b_e5_txn",  txn_a,  1);

        // zero delay
        req_z = 1'b1; en_z = 1'b1;
        step();
        chk("z_e0_ack",  ack_z,  1);
        chk("z_e0_busy", busy_z, 1);
        step();
        chk("z_e1_ack",  ack_z,  0);
        chk("z_e1_txn",  txn_z,  1);
        req_z = 1'b0;
        step();
        chk("z_idle", busy_z, 0);

        // paired with initiator
        use_init = 1'b1;
        rst = 1'b0;
        step();
        rst = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            a_hist[i] = ack_a;
            o_hist[i] = init_out;
        end
        bad = 0;
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            if (a_hist[i]) begin
                pulses++;
                if (i > 0 && a_hist[i-1]) bad++;
                if (i + 1 < 20 && !o_hist[i+1]) bad++;
                if (i + 2 < 20 && o_hist[i+2]) bad++;
            end
        end
        chk("pair_shape",  bad, 0);
        chk("pair_pulses", pulses, 3);
        chk("pair_txn",    txn_a, pulses);
        chk("pair_err",    err_a, 0);

        use_init = 1'b0; req_m = 1'b0;
        rst = 1'b0;
        step();
        rst = 1'b1;
        step();

        // withdrawal in WAIT
        en_a = 1'b1; req_m = 1'b1;
        step();
        chk("w_e0_busy", busy_a, 1);
        req_m = 1'b0;
        step();
        chk("w_busy", busy_a, 0);
        chk("w_err",  err_a,  1);
        chk("w_ack",  ack_a,  0);
        chk("w_txn",  txn_a,  0);
        clr_a = 1'b1;
        step();
        clr_a = 1'b0;
        chk("w_clr", err_a, 0);
        req_m = 1'b1;
        step();
        req_m = 1'b0; clr_a = 1'b1;
        step();
        clr_a = 1'b0;
        chk("w_setwins", err_a, 1);
        clr_a = 1'b1;
        step();
        clr_a = 1'b0;
        chk("w_clr2", err_a, 0);

        // gating and hold
        en_a = 1'b0; req_m = 1'b1;
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (ack_a || busy_a) bad++;
        end
        chk("g_gated", bad, 0);
        en_a = 1'b1;
        step();
        chk("g_start", busy_a, 1);
        en_a = 1'b0;
        step();
        step();
        chk("g_ack", ack_a, 1);
        bad = 0;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (ack_a) pulses++;
            if (!busy_a) bad++;
        end
        chk("h_noreack", pulses, 0);
        chk("h_busy",    bad,    0);
        chk("h_txn",     txn_a,  1);
        req_m = 1'b0;
        step();
        chk("h_idle", busy_a, 0);

        // 2-bit counter wrap, delay 1
        en_w = 1'b1;
        for (int k = 0; k < 5; k++) begin
            req_w = 1'b1;
            step();
            step();
            chk("wr_ack", ack_w, 1);
            step();
            chk("wr_txn", txn_w, wrap_exp[k]);
            req_w = 1'b0;
            step();
        end
        req_w = 1'b1;
        step();
        chk("wr_busy", busy_w, 1);
        #2 rst = 1'b0;
        #1;
        chk("ar_busy", busy_w, 0);
        chk("ar_ack",  ack_w,  0);
        chk("ar_err",  err_w,  0);
        chk("ar_txn",  txn_w,  0);
        chk("ar_txn_a", txn_a, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/hs_responder.md
# hs_responder

Responder end of the single-wire request/acknowledge handshake used by the block's 2-bit sequencing FSM. That initiator raises its request (its `Out`) after a fixed post-reset delay and holds it until it samples acknowledge (its `In`) high. This block watches that request line, waits a programmable number of cycles, returns a one-cycle acknowledge pulse, and waits for the request to drop. It also counts completed transactions and flags requests withdrawn before acknowledge.

## Interface
Parameters:
- `ACK_DELAY`, default 2: wait cycles between accepting a request and asserting `Ack`; legal range 0..15.
- `CNT_W`, default 8: width of `TxnCount`.

Ports:
- `clk`  input  1  clock; all state changes on rising edge.
- `rst`  input  1  reset, asynchronous, active-low.
- `Req`  input  1  request from initiator; level, synchronous to `clk`.
- `En`  input  1  accept enable; new requests are accepted only while high.
- `ClrErr`  input  1  synchronous clear of `Err`.
- `Ack`  output  1  acknowledge to initiator; registered, one-cycle pulse.
- `Busy`  output  1  high in any state other than IDLE.
- `Err`  output  1  sticky protocol-error flag.
- `TxnCount`  output  CNT_W  completed-transaction counter.

## Operation
- States (2-bit encoding): IDLE=00, WAIT=01, ACK=10, RELEASE=11. Wait counter `cnt` is 4 bits.
- IDLE: if `Req`=1 and `En`=1:
  - ACK_DELAY=0: go to ACK.
  - Otherwise: go to WAIT with `cnt`=0.
  - Else stay in IDLE.
- WAIT:
  - If `Req`=0: set `Err`=1 and go to IDLE. `TxnCount` is unchanged.
  - Else if `cnt`==ACK_DELAY-1: go to ACK.
  - Else `cnt`++.
- ACK: unconditionally go to RELEASE. `TxnCount` increments at this edge, modulo 2^CNT_W, wrapping from all-ones to 0. `Req` is not checked in ACK.
- RELEASE: if `Req`=0, go to IDLE; else stay. A held `Req` is never acknowledged twice.
- `Ack` = 1 exactly while state==ACK. Drive it from a register, not from decoded inputs.
- `Busy` = (state != IDLE).
- `Err`:
  - Set by a WAIT withdrawal.
  - Cleared when `ClrErr`=1.
  - If set and clear happen in the same cycle, set wins.
- `En` is sampled only in IDLE. Deasserting `En` mid-transaction has no effect on that transaction.
- State 2'b11 is RELEASE; there are no unreachable encodings.

## Timing
- Reset (rst=0, asynchronous) forces: state=IDLE, `cnt`=0, `Ack`=0, `Busy`=0, `Err`=0, `TxnCount`=0. Asserting reset mid-transaction aborts the transaction with no count and no error.
- Let edge E0 be the edge at which IDLE samples `Req`=1 and `En`=1.
  - `Ack` is high for the cycle following edge E0+ACK_DELAY.
  - ACK_DELAY=0: `Ack` is high right after E0.
  - ACK_DELAY=2: `Ack` is high after E2.
- `Ack` width is always exactly 1 cycle.
- `TxnCount` shows the new value in the cycle after the `Ack` pulse.
- Initiator pairing:
  - The initiator samples `Ack` at the edge ending the ACK cycle and drops `Req` one cycle later.
  - This block, in RELEASE, sees `Req`=0 at the next edge and returns to IDLE.
  - Minimum turnaround: IDLE is reached 2 edges after the `Ack` pulse ends.
- Back-to-back: a `Req` that stays high through RELEASE is not re-accepted. A fresh rising request is accepted at the first IDLE edge where `Req`=1.

## Test plan
- Reset then idle: rst=0 for 3 cycles, then rst=1 with `Req`=0 for 10 cycles -> `Ack`=0, `Busy`=0, `Err`=0, `TxnCount`=0 throughout.
- Basic handshake, ACK_DELAY=2, `En`=1:
  - `Req` rises before E0 -> `Busy`=1 after E0; `Ack`=1 only for the cycle after E2.
  - Drop `Req` one cycle after the `Ack` pulse -> IDLE 2 edges later; `TxnCount`=1.
- Paired with the sequencing FSM initiator, 20 cycles after reset release:
  - `Ack` pulses repeatedly, each pulse one cycle wide.
  - Initiator `Out` drops one cycle after each pulse.
  - `TxnCount` equals the number of pulses; `Err`=0.
- Withdrawal: `Req` high at E0, low at E1 -> state IDLE, `Err`=1, `TxnCount` unchanged, no `Ack`. Then:
  - `ClrErr`=1 for one cycle -> `Err`=0.
  - Repeat with `ClrErr`=1 in the same cycle as the withdrawal -> `Err`=1 (set wins).
- Gating and hold:
  - `En`=0 with `Req`=1 for 8 cycles -> no `Ack`, `Busy`=0.
  - Raise `En` -> transaction starts.
  - Keep `Req` high for 10 cycles after the `Ack` pulse -> exactly one `Ack` pulse, `Busy` stays 1.
- Wrap and reset: CNT_W=2, run 5 transactions -> `TxnCount` reads 1,2,3,0,1. Then assert rst while in WAIT -> all outputs 0 immediately, without waiting for a clock edge.
